data_feed_writer: RTL and testbench
===================================

// Module: data_feed_writer
// PURPOSE
//  Producer side of the pipeline data buffer. Accepts an external word stream (valid/ready), writes it into a
//  circular buffer of DEPTH words, and serves the main control unit's reads in windows of WIN words.
//  Generates wait_data / at_end_data / valid_start_addr for the controller; consumes read_spad / clr_addr / done_data.
//  Words are freed only on done_data, so a clr_addr rewind re-reads the current window.
// PARAMETERS
//  DATA_W  8   data word width
//  DEPTH   16  buffer words; power of 2, >= 2*WIN
//  ADDR_W  4   log2(DEPTH)
//  WIN     4   words per data window; power of 2, <= DEPTH
// PORTS
//  clk               in   1       single clock, rising edge
//  rst_n             in   1       asynchronous, active-low reset
//  start             in   1       pulse: begin accepting a stream (honoured only in IDLE)
//  in_valid          in   1       input word valid
//  in_data           in   DATA_W  input word
//  in_last           in   1       qualifies final word of stream
//  in_ready          out  1       buffer accepts word this cycle
//  read_spad         in   1       read next unread word (from controller)
//  clr_addr          in   1       rewind read pointer to current window base
//  done_data         in   1       release current window (WIN words)
//  rd_data           out  DATA_W  word read; valid 1 cycle after read_spad
//  rd_valid          out  1       rd_data valid
//  wait_data         out  1       no unread word available (rptr == wptr)
//  at_end_data       out  1       next word read is last of window (offset == WIN-1)
//  valid_start_addr  out  1       whole current window is resident (occ >= WIN)
//  feed_done         out  1       1-cycle pulse: stream fully written and drained
//  seq_err           out  1       sticky: done_data with occ < WIN; cleared only by reset
// BEHAVIOUR
//  Reset: in_ready=0, rd_data=0, rd_valid=0, wait_data=1, at_end_data=0, valid_start_addr=0, feed_done=0,
//   seq_err=0; wptr=rptr=base=0, occ=0, FSM=IDLE. Reset mid-stream discards all buffered data.
//  Pointers ADDR_W bits, wrap modulo DEPTH. occ = words in [base,wptr), range 0..DEPTH (ADDR_W+1 bits).
//   offset = rptr-base (mod DEPTH). Status outputs are combinational from registered state.
//  FSM: IDLE: start -> LOAD.
//   LOAD: in_ready = (occ < DEPTH). Write on in_valid&in_ready: mem[wptr]<=in_data, wptr++.
//    Accepted in_last: if total words written incl. this one is a multiple of WIN -> DRAIN, else -> PAD.
//   PAD: in_ready=0; write 0 at wptr each cycle with occ < DEPTH until total is a multiple of WIN -> DRAIN.
//   DRAIN: in_ready=0; when occ == 0 -> pulse feed_done for 1 cycle, -> IDLE.
//   start outside IDLE ignored.
//  Read: read_spad & !wait_data & !clr_addr: rd_data <= mem[rptr], rd_valid=1 next cycle, rptr++.
//   read_spad while wait_data: ignored, rd_valid=0, no pointer change.
//  clr_addr: rptr <= base; wins over same-cycle read_spad (no read issued).
//  done_data with occ >= WIN: base <= base+WIN, rptr <= base+WIN, occ -= WIN. With occ < WIN: no state
//   change, seq_err <= 1. done_data wins over clr_addr and read_spad in the same cycle.
//  Same-cycle write and release: occ <= occ + 1 - WIN. Full buffer with release same cycle: in_ready=0
//   that cycle (in_ready from registered occ only); write resumes next cycle.
//  Write/read never collide on unread data: wptr only advances into freed (released) slots.
// TESTING (DEPTH=16, WIN=4)
//  start, stream 8 words 0x10..0x17 (in_last on 0x17) -> DRAIN; valid_start_addr=1 after 4th write;
//   reads return 0x10..0x13, at_end_data=1 before 4th read; two done_data -> feed_done pulse, IDLE.
//  Stream 6 words 1..6 -> PAD writes 2 zeros; second window reads 5,6,0,0; feed_done after 2 done_data.
//  Stream 20 words, no reads -> in_ready drops after 16 accepted; one done_data (after 4 reads) ->
//   in_ready=1 next cycle, wptr wraps 15->0, word 17 at mem[0].
//  Read 3 words of window (0x10..0x12), clr_addr with read_spad same cycle -> no read; next read 0x10.
//  done_data with occ=2 -> seq_err=1 and sticky, base/rptr unchanged; read_spad on empty -> rd_valid=0.
//  rst_n low mid-LOAD with 9 words stored -> all outputs at reset values asynchronously, wait_data=1.

Source files
------------

// File: rtl/data_feed_writer.sv
// data_feed_writer
//   Producer side of the pipeline data buffer. An external valid/ready word
//   stream is written into a circular buffer of DEPTH words. The controller
//   reads the buffer in windows of WIN words. A window is freed only when the
//   controller asserts done_data, so a clr_addr rewind re-reads the current
//   window. A stream whose length is not a multiple of WIN is padded with
//   zero words up to the next window boundary.
//
// Ports
//   clk, rst_n        clock (rising edge); asynchronous active-low reset
//   start             begin accepting a stream (only honoured in IDLE)
//   in_valid/in_data  input word handshake; in_last marks the final word
//   in_ready          buffer accepts a word this cycle
//   read_spad         read next unread word; clr_addr rewinds to window base
//   done_data         release the current window (WIN words)
//   rd_data/rd_valid  read word, valid one cycle after read_spad
//   wait_data         no unread word is available
//   at_end_data       next word read is the last one of the window
//   valid_start_addr  the whole current window is resident
//   feed_done         one-cycle pulse: stream written and fully released
//   seq_err           sticky: done_data arrived with less than a window held

module data_feed_writer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIN    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              read_spad,
  input  logic              clr_addr,
  input  logic              done_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              wait_data,
  output logic              at_end_data,
  output logic              valid_start_addr,
  output logic              feed_done,
  output logic              seq_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    PAD   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   WIN_O    = (ADDR_W+1)'(WIN);
  localparam logic [ADDR_W:0]   WIN_END  = (ADDR_W+1)'(WIN - 1);
  localparam logic [ADDR_W-1:0] WIN_A    = ADDR_W'(WIN);
  localparam logic [ADDR_W-1:0] WIN_MASK = ADDR_W'(WIN - 1);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   ONE_O    = (ADDR_W+1)'(1);

  state_t              state_r;
  state_t              state_s;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic [ADDR_W-1:0]   wptr_r;
  logic [ADDR_W-1:0]   rptr_r;
  logic [ADDR_W-1:0]   base_r;
  // occ and read offset need one extra bit: both can reach DEPTH, which a
  // plain pointer difference could not tell apart from zero.
  logic [ADDR_W:0]     occ_r;
  logic [ADDR_W:0]     roff_r;
  logic [DATA_W-1:0]   rd_data_r;
  logic                rd_valid_r;
  logic                feed_done_r;
  logic                seq_err_r;

  logic                wr_en_s;
  logic [DATA_W-1:0]   wr_data_s;
  logic                drain_done_s;
  logic                aligned_s;
  logic                space_s;
  logic                rel_s;
  logic                err_s;
  logic                clr_s;
  logic                rd_en_s;

  // Status decode from registered state only
  always_comb begin
    space_s          = (occ_r < DEPTH_C);
    in_ready         = (state_r == LOAD) && space_s;
    wait_data        = (roff_r == occ_r);
    at_end_data      = (roff_r == WIN_END);
    valid_start_addr = (occ_r >= WIN_O);
    // Streams start on a window boundary, so the low bits of wptr track the
    // running word count modulo WIN.
    aligned_s        = (((wptr_r + ONE_A) & WIN_MASK) == {ADDR_W{1'b0}});
  end

  // Controller command priority: done_data, then clr_addr, then read_spad
  always_comb begin
    rel_s   = done_data && (occ_r >= WIN_O);
    err_s   = done_data && (occ_r < WIN_O);
    clr_s   = !done_data && clr_addr;
    rd_en_s = !done_data && !clr_addr && read_spad && !wait_data;
  end

  // Next-state and write-port control for the stream FSM
  always_comb begin
    state_s      = state_r;
    wr_en_s      = 1'b0;
    wr_data_s    = {DATA_W{1'b0}};
    drain_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (in_valid && in_ready) begin
          wr_en_s   = 1'b1;
          wr_data_s = in_data;
          if (in_last) begin
            if (aligned_s) begin
              state_s = DRAIN;
            end else begin
              state_s = PAD;
            end
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = LOAD;
        end
      end
      PAD: begin
        if (space_s) begin
          wr_en_s   = 1'b1;
          wr_data_s = {DATA_W{1'b0}};
          if (aligned_s) begin
            state_s = DRAIN;
          end else begin
            state_s = PAD;
          end
        end else begin
          state_s = PAD;
        end
      end
      DRAIN: begin
        if (occ_r == {(ADDR_W+1){1'b0}}) begin
          drain_done_s = 1'b1;
          state_s      = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Buffer storage; contents are meaningless until written so it has no reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wptr_r] <= wr_data_s;
    end
  end

  // Write pointer and occupancy (write and release may coincide)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r <= {ADDR_W{1'b0}};
      occ_r  <= {(ADDR_W+1){1'b0}};
    end else begin
      if (wr_en_s) begin
        wptr_r <= wptr_r + ONE_A;
      end
      occ_r <= occ_r + (wr_en_s ? ONE_O : {(ADDR_W+1){1'b0}})
                     - (rel_s ? WIN_O : {(ADDR_W+1){1'b0}});
    end
  end

  // Read side pointers: window base, read pointer and offset inside window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r <= {ADDR_W{1'b0}};
      rptr_r <= {ADDR_W{1'b0}};
      roff_r <= {(ADDR_W+1){1'b0}};
    end else if (rel_s) begin
      base_r <= base_r + WIN_A;
      rptr_r <= base_r + WIN_A;
      roff_r <= {(ADDR_W+1){1'b0}};
    end else if (clr_s) begin
      rptr_r <= base_r;
      roff_r <= {(ADDR_W+1){1'b0}};
    end else if (rd_en_s) begin
      rptr_r <= rptr_r + ONE_A;
      roff_r <= roff_r + ONE_O;
    end
  end

  // Registered read data, feed_done pulse and sticky sequencing error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r   <= {DATA_W{1'b0}};
      rd_valid_r  <= 1'b0;
      feed_done_r <= 1'b0;
      seq_err_r   <= 1'b0;
    end else begin
      if (rd_en_s) begin
        rd_data_r <= mem_r[rptr_r];
      end
      rd_valid_r  <= rd_en_s;
      feed_done_r <= drain_done_s;
      if (err_s) begin
        seq_err_r <= 1'b1;
      end
    end
  end

  assign rd_data   = rd_data_r;
  assign rd_valid  = rd_valid_r;
  assign feed_done = feed_done_r;
  assign seq_err   = seq_err_r;

endmodule

// File: tb/tb_data_feed_writer.sv
// Directed bench for data_feed_writer (DEPTH=16, WIN=4). Inputs change 1 time
// unit after the rising edge; outputs are checked at the same point.

module tb_data_feed_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       read_spad;
  logic       clr_addr;
  logic       done_data;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       wait_data;
  logic       at_end_data;
  logic       valid_start_addr;
  logic       feed_done;
  logic       seq_err;

  int total = 0;
  int bad   = 0;

  data_feed_writer #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .WIN(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .read_spad(read_spad), .clr_addr(clr_addr), .done_data(done_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .wait_data(wait_data),
    .at_end_data(at_end_data), .valid_start_addr(valid_start_addr),
    .feed_done(feed_done), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] exp);
    read_spad = 1'b1;
    tick();
    read_spad = 1'b0;
    chk({tag, "_valid"}, rd_valid, 1);
    chk(tag, rd_data, exp);
  endtask

  task automatic rel();
    done_data = 1'b1;
    tick();
    done_data = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_wait"}, wait_data, 1);
    chk({tag, "_at_end"}, at_end_data, 0);
    chk({tag, "_vsa"}, valid_start_addr, 0);
    chk({tag, "_feed_done"}, feed_done, 0);
    chk({tag, "_seq_err"}, seq_err, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    read_spad = 1'b0; clr_addr = 1'b0; done_data = 1'b0;
    #12;
    chk_reset("rst");
    rst_n = 1'b1;
    tick();

    // 8-word aligned stream, two windows
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      push(8'(8'h10 + i), i == 7);
      if (i == 2) chk("t1_vsa_3w", valid_start_addr, 0);
      if (i == 3) chk("t1_vsa_4w", valid_start_addr, 1);
    end
    chk("t1_ready_drain", in_ready, 0);
    chk("t1_wait", wait_data, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) chk("t1_at_end0", at_end_data, 0);
      if (i == 3) chk("t1_at_end3", at_end_data, 1);
      rd_chk("t1_rd", 8'(8'h10 + i));
    end
    rel();
    chk("t1_vsa_after_rel", valid_start_addr, 1);
    chk("t1_at_end_after_rel", at_end_data, 0);
    for (int i = 0; i < 4; i++) rd_chk("t1_rd2", 8'(8'h14 + i));
    rel();
    chk("t1_fd_early", feed_done, 0);
    chk("t1_wait_empty", wait_data, 1);
    tick();
    chk("t1_fd_pulse", feed_done, 1);
    tick();
    chk("t1_fd_clear", feed_done, 0);

    // 6-word stream padded with two zeros
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= 6; i++) push(8'(i), i == 6);
    tick(); tick();
    chk("t2_ready_drain", in_ready, 0);
    for (int i = 0; i < 4; i++) rd_chk("t2_rd", 8'(i + 1));
    rel();
    rd_chk("t2_rd5", 8'h05);
    rd_chk("t2_rd6", 8'h06);
    rd_chk("t2_pad0", 8'h00);
    rd_chk("t2_pad1", 8'h00);
    chk("t2_wait", wait_data, 1);
    rel();
    tick();
    chk("t2_fd_pulse", feed_done, 1);

    // 20-word stream filling the buffer, wrap of wptr
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      in_data = 8'(8'h40 + k);
      tick();
    end
    chk("t3_full_ready", in_ready, 0);
    in_data = 8'h51;
    tick();
    chk("t3_full_hold", in_ready, 0);
    for (int i = 0; i < 4; i++) rd_chk("t3_rd", 8'(8'h41 + i));
    done_data = 1'b1; tick(); done_data = 1'b0;
    chk("t3_ready_resume", in_ready, 1);
    for (int k = 17; k <= 20; k++) begin
      in_data = 8'(8'h40 + k);
      in_last = (k == 20);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("t3_ready_drain", in_ready, 0);
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 4; i++) rd_chk("t3_rdw", 8'(8'h45 + 4 * w + i));
      rel();
    end
    tick();
    chk("t3_fd_pulse", feed_done, 1);

    // clr_addr rewind, beating a same-cycle read
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i), i == 3);
    for (int i = 0; i < 3; i++) rd_chk("t4_rd", 8'(8'h10 + i));
    read_spad = 1'b1; clr_addr = 1'b1; tick(); read_spad = 1'b0; clr_addr = 1'b0;
    chk("t4_clr_no_read", rd_valid, 0);
    chk("t4_clr_at_end", at_end_data, 0);
    for (int i = 0; i < 4; i++) rd_chk("t4_reread", 8'(8'h10 + i));
    rel();
    tick();
    chk("t4_fd_pulse", feed_done, 1);

    // done_data with only two words held
    start = 1'b1; tick(); start = 1'b0;
    push(8'hA1, 1'b0);
    push(8'hA2, 1'b0);
    chk("t5_vsa", valid_start_addr, 0);
    chk("t5_err_before", seq_err, 0);
    rel();
    chk("t5_err_set", seq_err, 1);
    rd_chk("t5_rd_a1", 8'hA1);
    rd_chk("t5_rd_a2", 8'hA2);
    chk("t5_wait", wait_data, 1);
    read_spad = 1'b1; tick(); read_spad = 1'b0;
    chk("t5_empty_read", rd_valid, 0);
    tick();
    chk("t5_err_sticky", seq_err, 1);
    push(8'hA3, 1'b0);
    push(8'hA4, 1'b1);
    rd_chk("t5_rd_a3", 8'hA3);
    rd_chk("t5_rd_a4", 8'hA4);
    rel();
    tick();
    chk("t5_fd_pulse", feed_done, 1);
    chk("t5_err_kept", seq_err, 1);

    // asynchronous reset in the middle of a stream
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 9; i++) push(8'(8'h60 + i), 1'b0);
    chk("t6_vsa", valid_start_addr, 1);
    rd_chk("t6_rd", 8'h60);
    chk("t6_ready", in_ready, 1);
    rst_n = 1'b0;
    #2;
    chk_reset("t6_async");
    rst_n = 1'b1;
    tick();
    chk("t6_post_ready", in_ready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
